// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares the single write port of an 8-deep FIFO
// between two producers. Each winning request becomes one write transaction:
// a one-cycle wr_en, a wait for the FIFO's wr_ack/wr_err (bounded by
// TIMEOUT cycles), then a one-cycle done or err pulse back to the requester.
//
// Handshake: a producer raises reqN with stable dinN and holds both until it
// sees doneN or errN. The pulse cycle masks reqN, so a producer that drops
// req one cycle after the pulse is never written twice. wr_ack/wr_err are
// only looked at while waiting; anything arriving earlier is ignored.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   req0/din0          requester 0 request level and write data
//   req1/din1          requester 1 request level and write data
//   full               FIFO full flag (blocks new grants only)
//   wr_ack, wr_err     FIFO write acknowledge / write error
//   wr_en, dout        registered FIFO write strobe and data
//   gnt0, gnt1         registered grant, held from ISSUE through WAIT
//   done0, done1       one-cycle completion pulses
//   err0, err1         one-cycle failure pulses (wr_err or timeout)
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic                  full,
    input  logic                  wr_ack,
    input  logic                  wr_err,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic                  err0,
    output logic                  err1
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ISSUE = 2'b01;
    localparam logic [1:0] WAIT  = 2'b10;

    // Last WAIT count before the transaction is abandoned.
    localparam logic [2:0] TCNT_LAST = 3'(TIMEOUT - 1);

    logic [1:0] state;
    logic       sel;   // requester owning the current transaction
    logic       last;  // requester served most recently
    logic [2:0] tcnt;

    logic elig0;
    logic elig1;
    logic pick_valid;
    logic pick;

    // A requester whose pulse is showing this cycle is still dropping req.
    assign elig0      = req0 & ~done0 & ~err0;
    assign elig1      = req1 & ~done1 & ~err1;
    assign pick_valid = ~full & (elig0 | elig1);
    // On contention the requester that was not served last wins.
    assign pick       = (elig0 & elig1) ? ~last : elig1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
            tcnt  <= 3'd0;
            wr_en <= 1'b0;
            dout  <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
        end else begin
            // Pulses live for one cycle only.
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel   <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                        dout  <= pick ? din1 : din0;
                        wr_en <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_en <= 1'b0;
                    tcnt  <= 3'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (wr_ack || wr_err || (tcnt == TCNT_LAST)) begin
                        // wr_ack takes precedence over wr_err.
                        if (wr_ack) begin
                            done0 <= ~sel;
                            done1 <= sel;
                        end else begin
                            err0 <= ~sel;
                            err1 <= sel;
                        end
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        last  <= sel;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 3'd1;
                    end
                end
                default: begin
                    wr_en <= 1'b0;
                    dout  <= '0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    tcnt  <= 3'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: a directed vector table, a hand-written
// asynchronous reset sequence, and randomized traffic against a
// transaction-level reference model with a write-data scoreboard.
module tb_fifo_wr_arbiter;

    localparam int W       = 32;
    localparam int TIMEOUT = 4;

    logic         clk;
    logic         reset;
    logic         req0;
    logic [W-1:0] din0;
    logic         req1;
    logic [W-1:0] din1;
    logic         full;
    logic         wr_ack;
    logic         wr_err;
    logic         wr_en;
    logic [W-1:0] dout;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic         err0;
    logic         err1;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .din0(din0), .req1(req1), .din1(din1),
        .full(full), .wr_ack(wr_ack), .wr_err(wr_err),
        .wr_en(wr_en), .dout(dout), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: {wr_en, gnt0, gnt1, done0, done1, err0, err1}
    function automatic logic [6:0] flags_now();
        return {wr_en, gnt0, gnt1, done0, done1, err0, err1};
    endfunction

    task automatic check(input string name, input logic [6:0] xf, input logic [W-1:0] xd);
        checks++;
        if (flags_now() !== xf || dout !== xd) begin
            failures++;
            $display("FAIL %s: got flags=%b dout=%h, expected flags=%b dout=%h",
                     name, flags_now(), dout, xf, xd);
        end
    endtask

    task automatic drive(input logic r0, input logic [W-1:0] d0, input logic r1,
                         input logic [W-1:0] d1, input logic f, input logic a, input logic e);
        req0 = r0; din0 = d0; req1 = r1; din1 = d1;
        full = f; wr_ack = a; wr_err = e;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         r0;
        logic [W-1:0] d0;
        logic         r1;
        logic [W-1:0] d1;
        logic         f;
        logic         a;
        logic         e;
        logic [6:0]   xf;
        logic [W-1:0] xd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r0, input logic [W-1:0] d0, input logic r1,
                       input logic [W-1:0] d1, input logic f, input logic a, input logic e,
                       input logic [6:0] xf, input logic [W-1:0] xd);
        vec_t v;
        v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1;
        v.f = f; v.a = a; v.e = e; v.xf = xf; v.xd = xd;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // owner = -1 when no transaction is open; age = cycles since selection
    // (1 = issuing, >=2 = waiting).
    int           m_owner;
    int           m_age;
    int           m_last;
    bit           m_done[2];
    bit           m_err[2];
    logic [W-1:0] m_dout;
    logic [W-1:0] exp_q[$];

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_last = 1;
        m_done[0] = 0; m_done[1] = 0; m_err[0] = 0; m_err[1] = 0;
        m_dout = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit r[2], input logic [W-1:0] d[2],
                              input bit f, input bit a, input bit e);
        bit nd[2];
        bit ne[2];
        bit el[2];
        int pick;
        nd[0] = 0; nd[1] = 0; ne[0] = 0; ne[1] = 0;
        if (m_owner < 0) begin
            for (int i = 0; i < 2; i++) el[i] = r[i] && !m_done[i] && !m_err[i];
            if (!f && (el[0] || el[1])) begin
                if (el[0] && el[1]) pick = 1 - m_last;
                else pick = el[1] ? 1 : 0;
                m_owner = pick;
                m_age   = 1;
                m_dout  = d[pick];
                exp_q.push_back(d[pick]);
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            if (a || e || (m_age - 2 == TIMEOUT - 1)) begin
                if (a) nd[m_owner] = 1;
                else ne[m_owner] = 1;
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end
        m_done = nd;
        m_err  = ne;
    endtask

    function automatic logic [6:0] model_flags();
        return {(m_owner >= 0 && m_age == 1), (m_owner == 0), (m_owner == 1),
                m_done[0], m_done[1], m_err[0], m_err[1]};
    endfunction

    // ---------------- test ----------------
    initial begin
        bit           rr[2];
        logic [W-1:0] rd[2];
        bit           drop[2];
        bit           f, a, e;
        logic [W-1:0] got;

        reset = 1'b1;
        drive(0, '0, 0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 7'b0000000, '0);
        reset = 1'b0;

        // Single write, then mask of the still-held req in the done cycle.
        add(1, 32'hA5A5_0001, 0, 0, 0, 0, 0, 7'b1100000, 32'hA5A5_0001);
        add(1, 32'hA5A5_0001, 0, 0, 0, 0, 0, 7'b0100000, 32'hA5A5_0001);
        add(1, 32'hA5A5_0001, 0, 0, 0, 1, 0, 7'b0001000, 32'hA5A5_0001);
        add(1, 32'hA5A5_0001, 0, 0, 0, 0, 0, 7'b0000000, 32'hA5A5_0001);
        add(0, 32'hA5A5_0001, 0, 0, 0, 0, 0, 7'b0000000, 32'hA5A5_0001);
        // Write error on requester 0, pending requester 1 wins next.
        add(1, 32'h1111, 0, 32'h2222, 0, 0, 0, 7'b1100000, 32'h1111);
        add(1, 32'h1111, 1, 32'h2222, 0, 0, 0, 7'b0100000, 32'h1111);
        add(1, 32'h1111, 1, 32'h2222, 0, 0, 1, 7'b0000010, 32'h1111);
        add(1, 32'h1111, 1, 32'h2222, 0, 0, 0, 7'b1010000, 32'h2222);
        add(0, 32'h3333, 1, 32'h2222, 0, 0, 0, 7'b0010000, 32'h2222);
        add(1, 32'h3333, 1, 32'h2222, 0, 1, 0, 7'b0000100, 32'h2222);
        // Timeout: ack during ISSUE is ignored, 4 WAIT cycles, then err0.
        add(1, 32'h3333, 1, 32'h2222, 0, 0, 0, 7'b1100000, 32'h3333);
        add(1, 32'h3333, 0, 32'h2222, 0, 1, 0, 7'b0100000, 32'h3333);
        add(1, 32'h3333, 0, 32'h2222, 0, 0, 0, 7'b0100000, 32'h3333);
        add(1, 32'h3333, 0, 32'h2222, 0, 0, 0, 7'b0100000, 32'h3333);
        add(1, 32'h3333, 0, 32'h2222, 0, 0, 0, 7'b0100000, 32'h3333);
        add(1, 32'h3333, 0, 32'h2222, 0, 0, 0, 7'b0000010, 32'h3333);
        add(1, 32'h3333, 0, 32'h2222, 0, 0, 0, 7'b0000000, 32'h3333);
        add(0, 32'h3333, 0, 32'h2222, 0, 0, 0, 7'b0000000, 32'h3333);
        // Full back-pressure for 5 cycles, then grant; ack beats err.
        for (int i = 0; i < 5; i++)
            add(0, 32'h3333, 1, 32'h4444, 1, 0, 0, 7'b0000000, 32'h3333);
        add(0, 32'h3333, 1, 32'h4444, 0, 0, 0, 7'b1010000, 32'h4444);
        add(0, 32'h3333, 1, 32'h4444, 1, 0, 0, 7'b0010000, 32'h4444);
        add(0, 32'h3333, 1, 32'h4444, 1, 1, 1, 7'b0000100, 32'h4444);
        add(0, 32'h3333, 0, 32'h4444, 0, 0, 0, 7'b0000000, 32'h4444);
        // Contention: grant order 0,1,0 with round-robin.
        add(1, 32'hC0, 1, 32'hC1, 0, 0, 0, 7'b1100000, 32'hC0);
        add(1, 32'hC0, 1, 32'hC1, 0, 0, 0, 7'b0100000, 32'hC0);
        add(1, 32'hC0, 1, 32'hC1, 0, 1, 0, 7'b0001000, 32'hC0);
        add(1, 32'hC0, 1, 32'hC1, 0, 0, 0, 7'b1010000, 32'hC1);
        add(0, 32'hC0, 1, 32'hC1, 0, 0, 0, 7'b0010000, 32'hC1);
        add(1, 32'hC2, 1, 32'hC1, 0, 1, 0, 7'b0000100, 32'hC1);
        add(1, 32'hC2, 1, 32'hC1, 0, 0, 0, 7'b1100000, 32'hC2);
        add(1, 32'hC2, 0, 32'hC1, 0, 0, 0, 7'b0100000, 32'hC2);
        add(1, 32'hC2, 0, 32'hC1, 0, 1, 0, 7'b0001000, 32'hC2);
        add(1, 32'hC2, 0, 32'hC1, 0, 0, 0, 7'b0000000, 32'hC2);
        add(0, 32'hC2, 0, 32'hC1, 0, 0, 0, 7'b0000000, 32'hC2);
        // Leave requester 0 as last served, then open another write.
        add(1, 32'h6666, 0, 0, 0, 0, 0, 7'b1100000, 32'h6666);
        add(1, 32'h6666, 0, 0, 0, 0, 0, 7'b0100000, 32'h6666);
        add(1, 32'h6666, 0, 0, 0, 1, 0, 7'b0001000, 32'h6666);
        add(0, 32'h6666, 0, 0, 0, 0, 0, 7'b0000000, 32'h6666);
        add(1, 32'h7777, 0, 0, 0, 0, 0, 7'b1100000, 32'h7777);
        add(1, 32'h7777, 0, 0, 0, 0, 0, 7'b0100000, 32'h7777);

        foreach (tbl[i]) begin
            drive(tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1, tbl[i].f, tbl[i].a, tbl[i].e);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].xf, tbl[i].xd);
        end

        // Asynchronous reset while waiting: outputs clear before any edge.
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", 7'b0000000, '0);
        drive(1, 32'h7777, 1, 32'h8888, 0, 1, 0);
        @(posedge clk);
        #1;
        check("reset_held", 7'b0000000, '0);
        reset = 1'b0;
        wr_ack = 1'b0;
        @(posedge clk);
        #1;
        check("reset_rr_first", 7'b1100000, 32'h7777);
        @(posedge clk);
        #1;
        check("reset_rr_wait", 7'b0100000, 32'h7777);

        // Randomized traffic against the reference model.
        reset = 1'b1;
        drive(0, '0, 0, '0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        rr[0] = 0; rr[1] = 0; rd[0] = '0; rd[1] = '0; drop[0] = 0; drop[1] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (drop[i]) begin
                    rr[i] = 0;
                    drop[i] = 0;
                end else if (!rr[i] && $urandom_range(0, 1) == 1) begin
                    rr[i] = 1;
                    rd[i] = $urandom;
                end
            end
            f = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 7) == 0);
            drive(rr[0], rd[0], rr[1], rd[1], f, a, e);
            model_step(rr, rd, f, a, e);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", n), model_flags(), m_dout);
            if (wr_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_write: got dout=%h, expected no write", dout);
                end else begin
                    got = exp_q.pop_front();
                    if (dout !== got) begin
                        failures++;
                        $display("FAIL sb_data: got dout=%h, expected %h", dout, got);
                    end
                end
            end
            for (int i = 0; i < 2; i++)
                if (m_done[i] || m_err[i]) drop[i] = 1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_missing_write: got %0d pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
